// File: rtl/wall_scan_collider.sv
// rtl/wall_scan_collider.sv - scans a wall tile table for 4-direction edge contact with the player sprite
module wall_scan_collider #(
    parameter int N_WALLS = 16,
    parameter int IDX_W   = 4,
    parameter int POS_W   = 10,
    parameter int SIZE    = 20,
    parameter int OVERLAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [POS_W-1:0] i_pos_h_CY,
    input  logic [POS_W-1:0] i_pos_v_CY,
    output logic [IDX_W-1:0] o_wall_addr,
    input  logic [POS_W-1:0] i_wall_h,
    input  logic [POS_W-1:0] i_wall_v,
    input  logic             i_wall_en,
    output logic             o_busy,
    output logic             o_done,
    output logic [3:0]       o_collision,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_hit_idx
);

    localparam int                      DW     = POS_W + 2;
    localparam logic signed [DW-1:0]    C_SIZE = DW'(SIZE);
    localparam logic [IDX_W-1:0]        C_LAST = IDX_W'(N_WALLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic [POS_W-1:0]   r_pos_h;
    logic [POS_W-1:0]   r_pos_v;
    logic               r_rd_vld;
    logic [IDX_W-1:0]   r_rd_idx;
    logic [3:0]         r_acc;
    logic               r_acc_hit;
    logic [IDX_W-1:0]   r_acc_idx;

    logic signed [DW-1:0] w_dh;
    logic signed [DW-1:0] w_dv;
    logic signed [DW-1:0] w_adh;
    logic signed [DW-1:0] w_adv;
    logic                 w_hov;
    logic                 w_vov;
    logic [3:0]           w_mask;
    logic [3:0]           w_acc_next;
    logic [IDX_W-1:0]     w_idx_next;

    // Two guard bits keep the differences exact across the whole coordinate range.
    always_comb begin
        w_dh  = $signed({2'b00, i_wall_h}) - $signed({2'b00, r_pos_h});
        w_dv  = $signed({2'b00, i_wall_v}) - $signed({2'b00, r_pos_v});
        w_adh = w_dh[DW-1] ? -w_dh : w_dh;
        w_adv = w_dv[DW-1] ? -w_dv : w_dv;
        w_hov = w_adh < C_SIZE;
        w_vov = w_adv < C_SIZE;

        w_mask    = '0;
        w_mask[0] = w_vov && (w_dh == -C_SIZE);
        w_mask[1] = w_vov && (w_dh == C_SIZE);
        w_mask[2] = w_hov && (w_dv == C_SIZE);
        w_mask[3] = w_hov && (w_dv == -C_SIZE);
        if (OVERLAP != 0 && w_vov && w_hov) begin
            if (w_dh[DW-1] || (w_dh == '0)) w_mask[0] = 1'b1;
            else                            w_mask[1] = 1'b1;
            if (!w_dv[DW-1])                w_mask[2] = 1'b1;
            else                            w_mask[3] = 1'b1;
        end
        if (!(r_rd_vld && i_wall_en)) w_mask = '0;

        w_acc_next = r_acc | w_mask;
        w_idx_next = r_acc_idx;
        if (!r_acc_hit && (w_mask != '0)) w_idx_next = r_rd_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pos_h     <= '0;
            r_pos_v     <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_idx    <= '0;
            r_acc       <= '0;
            r_acc_hit   <= 1'b0;
            r_acc_idx   <= '0;
            o_wall_addr <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_collision <= '0;
            o_hit       <= 1'b0;
            o_hit_idx   <= '0;
        end else begin
            // Read data returned this cycle belongs to the address issued last cycle.
            r_rd_vld  <= (r_state == S_SCAN);
            r_rd_idx  <= o_wall_addr;
            r_acc     <= w_acc_next;
            r_acc_idx <= w_idx_next;
            if (w_mask != '0) r_acc_hit <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_pos_h     <= i_pos_h_CY;
                        r_pos_v     <= i_pos_v_CY;
                        r_acc       <= '0;
                        r_acc_hit   <= 1'b0;
                        r_acc_idx   <= '0;
                        o_wall_addr <= '0;
                        o_busy      <= 1'b1;
                        o_collision <= '0;
                        o_hit       <= 1'b0;
                        o_hit_idx   <= '0;
                        r_state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (o_wall_addr == C_LAST) r_state <= S_DRAIN;
                    else                       o_wall_addr <= o_wall_addr + IDX_W'(1);
                end
                S_DRAIN: begin
                    o_busy      <= 1'b0;
                    o_done      <= 1'b1;
                    o_collision <= w_acc_next;
                    o_hit       <= |w_acc_next;
                    o_hit_idx   <= w_idx_next;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    o_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wall_scan_collider.sv
// tb/tb_wall_scan_collider.sv - directed vector bench for wall_scan_collider in touch and overlap modes
module tb_wall_scan_collider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] pos_h = '0;
    logic [9:0] pos_v = '0;

    logic [9:0] mem_h [4];
    logic [9:0] mem_v [4];
    logic       mem_en [4];

    logic [1:0] addr0, addr1;
    logic [9:0] wh0, wv0, wh1, wv1;
    logic       wen0, wen1;
    logic       busy0, done0, hit0, busy1, done1, hit1;
    logic [3:0] col0, col1;
    logic [1:0] idx0, idx1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        wh0  <= mem_h[addr0];
        wv0  <= mem_v[addr0];
        wen0 <= mem_en[addr0];
        wh1  <= mem_h[addr1];
        wv1  <= mem_v[addr1];
        wen1 <= mem_en[addr1];
    end

    wall_scan_collider #(.N_WALLS(4), .IDX_W(2), .POS_W(10), .SIZE(20), .OVERLAP(0)) u_dut (
        .clk(clk), .rst(rst), .i_start(start), .i_pos_h_CY(pos_h), .i_pos_v_CY(pos_v),
        .o_wall_addr(addr0), .i_wall_h(wh0), .i_wall_v(wv0), .i_wall_en(wen0),
        .o_busy(busy0), .o_done(done0), .o_collision(col0), .o_hit(hit0), .o_hit_idx(idx0)
    );

    wall_scan_collider #(.N_WALLS(4), .IDX_W(2), .POS_W(10), .SIZE(20), .OVERLAP(1)) u_dut_ov (
        .clk(clk), .rst(rst), .i_start(start), .i_pos_h_CY(pos_h), .i_pos_v_CY(pos_v),
        .o_wall_addr(addr1), .i_wall_h(wh1), .i_wall_v(wv1), .i_wall_en(wen1),
        .o_busy(busy1), .o_done(done1), .o_collision(col1), .o_hit(hit1), .o_hit_idx(idx1)
    );

    typedef struct packed {
        logic [9:0]  ph;
        logic [9:0]  pv;
        logic [39:0] wh;
        logic [39:0] wv;
        logic [3:0]  wen;
        logic [3:0]  exp0;
        logic [1:0]  idx0;
        logic [3:0]  exp1;
        logic [1:0]  idx1;
    } vec_t;

    localparam int NV = 9;
    vec_t vec [NV];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        pos_h = v.ph;
        pos_v = v.pv;
        for (int k = 0; k < 4; k++) begin
            mem_h[k]  = v.wh[k*10 +: 10];
            mem_v[k]  = v.wv[k*10 +: 10];
            mem_en[k] = v.wen[k];
        end
    endtask

    // start is driven in cycle c when smask[c]; histories record cycles 1..ncyc
    task automatic run_seq(input logic [31:0] smask, input int ncyc,
                           output logic [31:0] dh0, output logic [31:0] dh1, output logic [31:0] bh0);
        dh0 = '0; dh1 = '0; bh0 = '0;
        for (int c = 0; c < ncyc; c++) begin
            start = smask[c];
            @(posedge clk); #1;
            dh0[c+1] = done0;
            dh1[c+1] = done1;
            bh0[c+1] = busy0;
        end
        start = 1'b0;
    endtask

    logic [31:0] dh0, dh1, bh0;

    initial begin
        vec[0] = '{ph:100,  pv:100,  wh:{10'd0,10'd0,10'd80,10'd0},         wv:{10'd0,10'd0,10'd105,10'd0},
                   wen:4'b0010, exp0:4'b0001, idx0:2'd1, exp1:4'b0001, idx1:2'd1};
        vec[1] = '{ph:100,  pv:100,  wh:{10'd100,10'd100,10'd500,10'd120}, wv:{10'd80,10'd120,10'd500,10'd100},
                   wen:4'b1111, exp0:4'b1110, idx0:2'd0, exp1:4'b1110, idx1:2'd0};
        vec[2] = '{ph:0,    pv:0,    wh:{10'd1023,10'd0,10'd1004,10'd10},  wv:{10'd1023,10'd20,10'd0,10'd1000},
                   wen:4'b1111, exp0:4'b0100, idx0:2'd2, exp1:4'b0100, idx1:2'd2};
        vec[3] = '{ph:100,  pv:100,  wh:{10'd80,10'd80,10'd100,10'd120},   wv:{10'd105,10'd80,10'd125,10'd120},
                   wen:4'b0111, exp0:4'b0000, idx0:2'd0, exp1:4'b0000, idx1:2'd0};
        vec[4] = '{ph:100,  pv:100,  wh:{10'd110,10'd0,10'd0,10'd0},       wv:{10'd105,10'd0,10'd0,10'd0},
                   wen:4'b1000, exp0:4'b0000, idx0:2'd0, exp1:4'b0110, idx1:2'd3};
        vec[5] = '{ph:200,  pv:200,  wh:{10'd200,10'd220,10'd200,10'd180}, wv:{10'd220,10'd210,10'd180,10'd200},
                   wen:4'b1110, exp0:4'b1110, idx0:2'd1, exp1:4'b1110, idx1:2'd1};
        vec[6] = '{ph:300,  pv:300,  wh:{10'd0,10'd0,10'd0,10'd295},       wv:{10'd0,10'd0,10'd0,10'd290},
                   wen:4'b0001, exp0:4'b0000, idx0:2'd0, exp1:4'b1001, idx1:2'd0};
        vec[7] = '{ph:1003, pv:1003, wh:{10'd0,10'd0,10'd0,10'd1023},      wv:{10'd0,10'd0,10'd1003,10'd1003},
                   wen:4'b0011, exp0:4'b0010, idx0:2'd0, exp1:4'b0010, idx1:2'd0};
        vec[8] = '{ph:50,   pv:50,   wh:{10'd0,10'd0,10'd0,10'd50},        wv:{10'd0,10'd0,10'd0,10'd50},
                   wen:4'b0001, exp0:4'b0000, idx0:2'd0, exp1:4'b0101, idx1:2'd0};
        load(vec[0]);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_addr", {30'd0, addr0}, 32'd0);
        chk("rst_col",  {28'd0, col0}, 32'd0);
        chk("rst_hit",  {31'd0, hit0}, 32'd0);
        chk("rst_idx",  {30'd0, idx0}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            load(vec[i]);
            run_seq(32'h1, 10, dh0, dh1, bh0);
            chk($sformatf("v%0d_done_t", i),    dh0, 32'h40);
            chk($sformatf("v%0d_done_t_ov", i), dh1, 32'h40);
            chk($sformatf("v%0d_busy_t", i),    bh0, 32'h3E);
            chk($sformatf("v%0d_col", i),    {28'd0, col0}, {28'd0, vec[i].exp0});
            chk($sformatf("v%0d_hit", i),    {31'd0, hit0}, {31'd0, |vec[i].exp0});
            chk($sformatf("v%0d_idx", i),    {30'd0, idx0}, {30'd0, vec[i].idx0});
            chk($sformatf("v%0d_col_ov", i), {28'd0, col1}, {28'd0, vec[i].exp1});
            chk($sformatf("v%0d_hit_ov", i), {31'd0, hit1}, {31'd0, |vec[i].exp1});
            chk($sformatf("v%0d_idx_ov", i), {30'd0, idx1}, {30'd0, vec[i].idx1});
        end

        // starts at cycles 0, 3 (busy) and 6 (DONE) are all one scan
        load(vec[1]);
        run_seq(32'h49, 14, dh0, dh1, bh0);
        chk("ign_done_t", dh0, 32'h40);
        chk("ign_busy_t", bh0, 32'h3E);
        chk("ign_col", {28'd0, col0}, 32'hE);

        // start in the cycle right after DONE is accepted
        load(vec[0]);
        run_seq(32'h81, 16, dh0, dh1, bh0);
        chk("b2b_done_t", dh0, 32'h2040);
        chk("b2b_busy_t", bh0, 32'h1F3E);
        chk("b2b_col", {28'd0, col0}, 32'h1);

        // async reset in cycle 3 of a scan, with a nonzero prior result held
        load(vec[1]);
        run_seq(32'h1, 8, dh0, dh1, bh0);
        chk("pre_rst_col", {28'd0, col0}, 32'hE);
        run_seq(32'h1, 3, dh0, dh1, bh0);
        chk("pre_rst_busy", {31'd0, busy0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_done", {31'd0, done0}, 32'd0);
        chk("abort_addr", {30'd0, addr0}, 32'd0);
        chk("abort_col",  {28'd0, col0}, 32'd0);
        chk("abort_hit",  {31'd0, hit0}, 32'd0);
        chk("abort_idx",  {30'd0, idx0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_seq(32'h0, 12, dh0, dh1, bh0);
        chk("abort_no_done", dh0 | dh1, 32'd0);
        chk("abort_no_busy", bh0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
